// File: rtl/nn_pkg.sv
// Shared types and helpers for the FP32 dot-product neuron.
package nn_pkg;
  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_ZERO = 32'h0;
  localparam int    FP32_SIGN = 31;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} nn_dot_state_e;

  // Anything with the sign bit set clamps to +0, including -0 and negative NaN.
  function automatic fp32_t relu_f(input fp32_t v, input logic en);
    return (en && v[FP32_SIGN]) ? FP32_ZERO : v;
  endfunction
endpackage

// File: rtl/Float_Add.sv
// Combinational FP32 add: denormals flush to zero, mantissa truncated after normalisation.
module Float_Add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        w_big_a, w_s;
  logic [7:0]  w_ea, w_eb, w_e_big, w_d;
  logic [26:0] w_m_big, w_m_sml, w_m_sum, w_norm;
  logic [4:0]  w_lz;
  logic signed [9:0] w_e;

  always_comb begin
    w_ea    = a[30:23];
    w_eb    = b[30:23];
    w_big_a = (a[30:0] >= b[30:0]);
    w_e_big = w_big_a ? w_ea : w_eb;
    w_d     = w_big_a ? (w_ea - w_eb) : (w_eb - w_ea);
    w_s     = w_big_a ? a[31] : b[31];
    w_m_big = {2'b01, (w_big_a ? a[22:0] : b[22:0]), 2'b00};
    w_m_sml = {2'b01, (w_big_a ? b[22:0] : a[22:0]), 2'b00};
    w_m_sml = (w_d > 8'd26) ? 27'd0 : (w_m_sml >> w_d);
    w_m_sum = (a[31] == b[31]) ? (w_m_big + w_m_sml) : (w_m_big - w_m_sml);
    // Highest set bit wins: the ascending scan leaves the smallest shift.
    w_lz    = 5'd0;
    for (int i = 0; i < 27; i++)
      if (w_m_sum[i]) w_lz = 5'(26 - i);
    w_norm  = w_m_sum << w_lz;
    w_e     = $signed({2'b00, w_e_big}) + 10'sd1 - $signed({5'd0, w_lz});
    y       = 32'd0;
    if (w_ea == 8'hFF || w_eb == 8'hFF) begin
      if (w_ea == 8'hFF && w_eb == 8'hFF && a != b) y = 32'h7FC00000;
      else y = (w_ea == 8'hFF) ? a : b;
    end
    else if (w_ea == 8'd0) y = (w_eb == 8'd0) ? {a[31] & b[31], 31'd0} : b;
    else if (w_eb == 8'd0) y = a;
    else if (w_m_sum == 27'd0) y = 32'd0;
    else if (w_e >= 10'sd255)  y = {w_s, 8'hFF, 23'd0};
    else if (w_e <= 10'sd0)    y = {w_s, 31'd0};
    else y = {w_s, w_e[7:0], w_norm[25:3]};
  end
endmodule

// File: rtl/Float_Mul.sv
// Combinational FP32 multiply: denormals flush to zero, mantissa truncated.
module Float_Mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        w_s, w_nan;
  logic [7:0]  w_ea, w_eb;
  logic [47:0] w_prod;
  logic signed [9:0] w_e;

  always_comb begin
    w_ea   = a[30:23];
    w_eb   = b[30:23];
    w_s    = a[31] ^ b[31];
    w_nan  = (w_ea == 8'hFF && a[22:0] != 23'd0) || (w_eb == 8'hFF && b[22:0] != 23'd0) ||
             (w_ea == 8'hFF && w_eb == 8'd0) || (w_eb == 8'hFF && w_ea == 8'd0);
    w_prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    w_e    = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127 + (w_prod[47] ? 10'sd1 : 10'sd0);
    y      = {w_s, 31'd0};
    if (w_nan)                            y = 32'h7FC00000;
    else if (w_ea == 8'hFF || w_eb == 8'hFF) y = {w_s, 8'hFF, 23'd0};
    else if (w_ea == 8'd0 || w_eb == 8'd0)   y = {w_s, 31'd0};
    else if (w_e >= 10'sd255)                y = {w_s, 8'hFF, 23'd0};
    else if (w_e <= 10'sd0)                  y = {w_s, 31'd0};
    else y = {w_s, w_e[7:0], w_prod[47] ? w_prod[46:24] : w_prod[45:23]};
  end
endmodule

// File: rtl/nn_fp_adder_tree.sv
// Pairwise FP32 reduction tree; node k sums nodes 2k and 2k+1, leaves at LANES..2*LANES-1.
module nn_fp_adder_tree import nn_pkg::*; #(
  parameter int LANES = 16
) (
  input  logic [LANES*32-1:0] i_lanes,
  output fp32_t               o_sum
);
  fp32_t w_node [1:2*LANES-1];

  for (genvar i = 0; i < LANES; i++) begin : gen_leaf
    assign w_node[LANES+i] = i_lanes[32*i +: 32];
  end

  for (genvar k = 1; k < LANES; k++) begin : gen_node
    Float_Add u_add (.a(w_node[2*k]), .b(w_node[2*k+1]), .y(w_node[k]));
  end

  assign o_sum = w_node[1];
endmodule

// File: rtl/nn_dot_engine.sv
// FP32 neuron: chunked multiply, tree reduce, accumulate, bias, optional ReLU, valid/ready result.
module nn_dot_engine import nn_pkg::*; #(
  parameter int LANES      = 16,
  parameter int MAX_CHUNKS = 64,
  parameter int CNT_W      = $clog2(MAX_CHUNKS+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_chunks,
  input  fp32_t              bias,
  input  logic               relu_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*32-1:0] x_flat,
  input  logic [LANES*32-1:0] w_flat,
  output logic               out_valid,
  input  logic               out_ready,
  output fp32_t              out_data,
  output logic               busy
);
  nn_dot_state_e          r_state;
  logic [CNT_W-1:0]       r_num, r_accepted, r_summed, w_num_sat;
  fp32_t                  r_bias, r_sum, r_acc, w_tree, w_acc_next, w_biased;
  logic                   r_relu, w_fire;
  logic [LANES-1:0][31:0] w_prod, r_prod;
  logic [1:0]             r_vld_pipe;

  assign in_ready  = (r_state == RUN) && (r_accepted < r_num);
  assign w_fire    = in_valid && in_ready;
  assign busy      = (r_state != IDLE);
  assign w_num_sat = (num_chunks > CNT_W'(MAX_CHUNKS)) ? CNT_W'(MAX_CHUNKS) : num_chunks;

  for (genvar i = 0; i < LANES; i++) begin : gen_mul
    Float_Mul u_mul (.a(x_flat[32*i +: 32]), .b(w_flat[32*i +: 32]), .y(w_prod[i]));
  end

  nn_fp_adder_tree #(.LANES(LANES)) u_tree (.i_lanes(r_prod), .o_sum(w_tree));
  Float_Add u_acc  (.a(r_acc), .b(r_sum),  .y(w_acc_next));
  Float_Add u_bias (.a(r_acc), .b(r_bias), .y(w_biased));

  // Never stalls: one chunk per cycle flows product -> sum -> accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod     <= '0;
      r_sum      <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_fire};
      if (w_fire)        r_prod <= w_prod;
      if (r_vld_pipe[0]) r_sum  <= w_tree;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_num      <= '0;
      r_accepted <= '0;
      r_summed   <= '0;
      r_bias     <= FP32_ZERO;
      r_relu     <= 1'b0;
      r_acc      <= FP32_ZERO;
      out_valid  <= 1'b0;
      out_data   <= FP32_ZERO;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_num      <= w_num_sat;
          r_bias     <= bias;
          r_relu     <= relu_en;
          r_acc      <= FP32_ZERO;
          r_accepted <= '0;
          r_summed   <= '0;
          r_state    <= RUN;
        end
        RUN:   if (r_accepted == r_num) r_state <= DRAIN;
        DRAIN: if (r_summed == r_num) begin
          out_data  <= relu_f(w_biased, r_relu);
          out_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE:  if (out_ready) begin
          out_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_fire) r_accepted <= r_accepted + 1'b1;
      if (r_vld_pipe[1]) begin
        r_acc    <= (r_summed == '0) ? r_sum : w_acc_next;
        r_summed <= r_summed + 1'b1;
      end
    end
  end
endmodule
